// File: rtl/deskew_ctrl.sv
// rtl/deskew_ctrl.sv - supervisory sequencer for the 100GbE PCS receive lane deskew engine
module deskew_ctrl #(
  parameter int N_LANES        = 20,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DESKEW_TIMEOUT = 1024,
  parameter int MAX_RETRIES    = 4,
  parameter int HOLDOFF_CYCLES = 256,
  parameter int MAX_ALIGN_ERR  = 3,
  parameter int NB_TIMER       = $clog2(DESKEW_TIMEOUT + 1),
  parameter int NB_RETRY       = $clog2(MAX_RETRIES + 1)
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic [N_LANES-1:0]  i_lane_am_lock,
  input  logic                i_deskew_done,
  input  logic                i_invalid_skew,
  input  logic                i_align_err,
  output logic                o_deskew_enable,
  output logic                o_resync,
  output logic                o_am_lock_all,
  output logic                o_align_status,
  output logic [NB_RETRY-1:0] o_retry_count,
  output logic                o_fail,
  output logic [2:0]          o_state
);

  localparam int NB_ERR = $clog2(MAX_ALIGN_ERR + 1);

  localparam logic [NB_TIMER-1:0] SETTLE_LAST  = NB_TIMER'(SETTLE_CYCLES - 1);
  localparam logic [NB_TIMER-1:0] TIMEOUT_LAST = NB_TIMER'(DESKEW_TIMEOUT - 1);
  localparam logic [NB_TIMER-1:0] HOLDOFF_LAST = NB_TIMER'(HOLDOFF_CYCLES - 1);
  localparam logic [NB_RETRY-1:0] RETRY_LIMIT  = NB_RETRY'(MAX_RETRIES);
  localparam logic [NB_ERR-1:0]   ERR_LIMIT    = NB_ERR'(MAX_ALIGN_ERR);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    DESKEW    = 3'd2,
    ALIGNED   = 3'd3,
    RESYNC    = 3'd4,
    FAIL      = 3'd5
  } state_t;

  state_t              state, state_next;
  logic [NB_TIMER-1:0] timer, timer_next;
  logic [NB_RETRY-1:0] retry, retry_next, retry_inc;
  logic [NB_ERR-1:0]   err_cnt, err_next, err_inc;
  logic                step;
  logic                lock_all;

  assign step      = i_enable && i_valid;
  assign lock_all  = &i_lane_am_lock;
  assign retry_inc = retry + 1'b1;
  assign err_inc   = err_cnt + 1'b1;

  always_comb begin
    state_next = state;
    timer_next = timer;
    retry_next = retry;
    err_next   = err_cnt;
    case (state)
      WAIT_LOCK: begin
        if (lock_all) state_next = SETTLE;
      end
      SETTLE: begin
        if (!lock_all)                state_next = WAIT_LOCK;
        else if (timer == SETTLE_LAST) state_next = DESKEW;
        else                          timer_next = timer + 1'b1;
      end
      DESKEW: begin
        // Invalid skew and timeout share one branch so a coincident pair counts once.
        if (!lock_all) begin
          state_next = WAIT_LOCK;
        end else if (i_invalid_skew || (timer == TIMEOUT_LAST)) begin
          retry_next = retry_inc;
          state_next = (retry_inc == RETRY_LIMIT) ? FAIL : RESYNC;
        end else if (i_deskew_done) begin
          state_next = ALIGNED;
          retry_next = '0;
          err_next   = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      ALIGNED: begin
        if (!lock_all) begin
          state_next = WAIT_LOCK;
        end else begin
          err_next = i_align_err ? err_inc : '0;
          if (!i_deskew_done || (i_align_err && (err_inc == ERR_LIMIT)))
            state_next = RESYNC;
        end
      end
      RESYNC: begin
        state_next = lock_all ? SETTLE : WAIT_LOCK;
      end
      FAIL: begin
        if (timer == HOLDOFF_LAST) state_next = WAIT_LOCK;
        else                       timer_next = timer + 1'b1;
      end
      default: begin
        state_next = WAIT_LOCK;
      end
    endcase
    if (state_next != state)     timer_next = '0;
    if (state_next == WAIT_LOCK) retry_next = '0;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= WAIT_LOCK;
      timer           <= '0;
      retry           <= '0;
      err_cnt         <= '0;
      o_am_lock_all   <= 1'b0;
      o_resync        <= 1'b0;
      o_deskew_enable <= 1'b0;
      o_align_status  <= 1'b0;
      o_fail          <= 1'b0;
    end else begin
      o_resync <= 1'b0;
      if (step) begin
        state           <= state_next;
        timer           <= timer_next;
        retry           <= retry_next;
        err_cnt         <= err_next;
        o_am_lock_all   <= lock_all;
        o_resync        <= (state_next == RESYNC) && (state != RESYNC);
        o_deskew_enable <= (state_next == DESKEW) || (state_next == ALIGNED);
        o_align_status  <= (state_next == ALIGNED);
        o_fail          <= (state_next == FAIL);
      end
    end
  end

  assign o_retry_count = retry;
  assign o_state       = state;

endmodule
